mips32_mc_control: RTL and testbench

- Multi-cycle successor to the single-cycle MIPS32 decoder: an FSM sequencing FETCH/DECODE/EXEC/MEM/WB over a shared memory port, with a ready handshake, a bus timeout and a trap state.
- Sits beside the multi-cycle datapath (PC, IR, MDR, A/B, ALUOut regs).
- Opcode and function come from the IR, which is stable from the end of FETCH.

---
 rtl/mips32_mc_control_if.sv | 41 ++++
 rtl/mips32_mc_control.sv | 188 ++++++++++++++++++
 tb/tb_mips32_mc_control.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips32_mc_control_if.sv
// Control bundle between the multi-cycle MIPS32 sequencer and its datapath:
// IR fields and memory ready in, datapath/memory strobes and status out.
interface mips32_mc_control_if #(
  parameter int ALU_FUNC_W = 3
);
  logic [5:0]            opc;
  logic [5:0]            func;
  logic                  memReady;
  logic                  irWrite;
  logic                  pcWrite;
  logic                  isBeq;
  logic                  isBne;
  logic [1:0]            pcSrc;
  logic                  iOrD;
  logic                  memRead;
  logic                  memWrite;
  logic                  rfWriteEnable;
  logic                  rfWriteAddrSel;
  logic [1:0]            rfWriteDataSel;
  logic                  aluSrcA;
  logic [1:0]            aluSrcB;
  logic [ALU_FUNC_W-1:0] aluFunc;
  logic                  bitXtend;
  logic                  invOpcode;
  logic                  memErr;
  logic [2:0]            state;

  modport master (
    input  opc, func, memReady,
    output irWrite, pcWrite, isBeq, isBne, pcSrc, iOrD, memRead, memWrite,
           rfWriteEnable, rfWriteAddrSel, rfWriteDataSel, aluSrcA, aluSrcB,
           aluFunc, bitXtend, invOpcode, memErr, state
  );

  modport slave (
    output opc, func, memReady,
    input  irWrite, pcWrite, isBeq, isBne, pcSrc, iOrD, memRead, memWrite,
           rfWriteEnable, rfWriteAddrSel, rfWriteDataSel, aluSrcA, aluSrcB,
           aluFunc, bitXtend, invOpcode, memErr, state
  );
endinterface

// File: rtl/mips32_mc_control.sv
// Multi-cycle MIPS32 control sequencer: FETCH/DECODE/EXEC/MEM/WB over a shared
// memory port with a ready handshake, a bus timeout and a sticky trap state.
module mips32_mc_control #(
  parameter int ALU_FUNC_W      = 3,
  parameter int MEM_TIMEOUT     = 15,
  parameter bit TRAP_ON_INVALID = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  mips32_mc_control_if.master bus
);

  // state  | meaning
  // FETCH  | read instruction at PC; IR and PC+4 load on memReady
  // DECODE | classify opcode, branch target into ALUOut
  // EXEC   | ALU op, address calc, or branch/jump PC update
  // MEM    | data access at ALUOut, held until memReady
  // WB     | single-cycle register-file write
  // TRAP   | invalid instruction or bus timeout, left only by rst
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  localparam logic [ALU_FUNC_W-1:0] ALU_ADD = ALU_FUNC_W'(3'b010);
  localparam logic [ALU_FUNC_W-1:0] ALU_SUB = ALU_FUNC_W'(3'b110);
  localparam logic [ALU_FUNC_W-1:0] ALU_AND = ALU_FUNC_W'(3'b000);
  localparam logic [ALU_FUNC_W-1:0] ALU_OR  = ALU_FUNC_W'(3'b001);
  localparam logic [ALU_FUNC_W-1:0] ALU_SLT = ALU_FUNC_W'(3'b111);

  typedef struct packed {
    logic                  ir_write;
    logic                  pc_write;
    logic                  is_beq;
    logic                  is_bne;
    logic [1:0]            pc_src;
    logic                  i_or_d;
    logic                  mem_read;
    logic                  mem_write;
    logic                  rf_we;
    logic                  rf_addr_sel;
    logic [1:0]            rf_data_sel;
    logic                  alu_src_a;
    logic [1:0]            alu_src_b;
    logic [ALU_FUNC_W-1:0] alu_func;
    logic                  bit_xtend;
  } ctl_t;

  state_t                state_q, state_nxt;
  logic [CNT_W-1:0]      cnt_q;
  logic                  inv_q, err_q;
  ctl_t                  ctl;
  logic [ALU_FUNC_W-1:0] r_func;
  logic                  r_ok;
  logic                  is_r, is_addi, is_slti, is_andi, is_ori;
  logic                  is_lw, is_sw, is_beq, is_bne, is_j, valid;
  logic                  wait_st, timeout;

  always_comb begin
    r_func = ALU_ADD;
    r_ok   = 1'b1;
    case (bus.func)
      6'h20:   r_func = ALU_ADD;
      6'h22:   r_func = ALU_SUB;
      6'h24:   r_func = ALU_AND;
      6'h25:   r_func = ALU_OR;
      6'h2A:   r_func = ALU_SLT;
      default: r_ok   = 1'b0;
    endcase
  end

  assign is_r    = (bus.opc == 6'h00) && r_ok;
  assign is_addi = (bus.opc == 6'h08);
  assign is_slti = (bus.opc == 6'h0A);
  assign is_andi = (bus.opc == 6'h0C);
  assign is_ori  = (bus.opc == 6'h0D);
  assign is_lw   = (bus.opc == 6'h23);
  assign is_sw   = (bus.opc == 6'h2B);
  assign is_beq  = (bus.opc == 6'h04);
  assign is_bne  = (bus.opc == 6'h05);
  assign is_j    = (bus.opc == 6'h02);
  assign valid   = is_r | is_addi | is_slti | is_andi | is_ori | is_lw | is_sw |
                   is_beq | is_bne | is_j;

  // A ready arriving in the cycle the count hits the limit beats the timeout.
  assign wait_st = ((state_q == S_FETCH) || (state_q == S_MEM)) && !bus.memReady;
  assign timeout = (MEM_TIMEOUT > 0) && wait_st && (cnt_q == CNT_W'(MEM_TIMEOUT));

  always_comb begin
    state_nxt = state_q;
    ctl       = '0;
    case (state_q)
      S_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = 2'b01;
        ctl.alu_func  = ALU_ADD;
        ctl.ir_write  = bus.memReady;
        ctl.pc_write  = bus.memReady;
        if (timeout)           state_nxt = S_TRAP;
        else if (bus.memReady) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        ctl.alu_src_b = 2'b11;
        ctl.alu_func  = ALU_ADD;
        if (valid)                state_nxt = S_EXEC;
        else if (TRAP_ON_INVALID) state_nxt = S_TRAP;
        else                      state_nxt = S_FETCH;
      end
      S_EXEC: begin
        state_nxt = S_FETCH;
        if (is_r) begin
          ctl.alu_src_a = 1'b1;
          ctl.alu_func  = r_func;
          state_nxt     = S_WB;
        end else if (is_addi || is_slti) begin
          ctl.alu_src_b = 2'b10;
          ctl.alu_func  = is_slti ? ALU_SLT : ALU_ADD;
          state_nxt     = S_WB;
        end else if (is_andi || is_ori) begin
          ctl.alu_src_b = 2'b10;
          ctl.bit_xtend = 1'b1;
          ctl.alu_func  = is_ori ? ALU_OR : ALU_AND;
          state_nxt     = S_WB;
        end else if (is_lw || is_sw) begin
          ctl.alu_src_a = 1'b1;
          ctl.alu_src_b = 2'b10;
          ctl.alu_func  = ALU_ADD;
          state_nxt     = S_MEM;
        end else if (is_beq || is_bne) begin
          ctl.alu_src_a = 1'b1;
          ctl.alu_func  = ALU_SUB;
          ctl.pc_src    = 2'b01;
          ctl.is_beq    = is_beq;
          ctl.is_bne    = is_bne;
        end else if (is_j) begin
          ctl.pc_write  = 1'b1;
          ctl.pc_src    = 2'b10;
        end
      end
      S_MEM: begin
        ctl.i_or_d    = 1'b1;
        ctl.mem_write = is_sw;
        ctl.mem_read  = !is_sw;
        if (timeout)           state_nxt = S_TRAP;
        else if (bus.memReady) state_nxt = is_sw ? S_FETCH : S_WB;
      end
      S_WB: begin
        ctl.rf_we       = 1'b1;
        ctl.rf_addr_sel = is_r;
        ctl.rf_data_sel = is_lw ? 2'b01 : 2'b00;
        state_nxt       = S_FETCH;
      end
      S_TRAP:  state_nxt = S_TRAP;
      default: state_nxt = S_TRAP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      inv_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= (wait_st && !timeout) ? cnt_q + CNT_W'(1) : '0;
      if (timeout) err_q <= 1'b1;
      // Sticky while trapped; otherwise a single-cycle pulse in the following FETCH.
      if ((state_q == S_DECODE) && !valid) inv_q <= 1'b1;
      else if (state_q != S_TRAP)          inv_q <= 1'b0;
    end
  end

  assign {bus.irWrite, bus.pcWrite, bus.isBeq, bus.isBne, bus.pcSrc, bus.iOrD,
          bus.memRead, bus.memWrite, bus.rfWriteEnable, bus.rfWriteAddrSel,
          bus.rfWriteDataSel, bus.aluSrcA, bus.aluSrcB, bus.aluFunc,
          bus.bitXtend} = rst ? ctl_t'(0) : ctl;
  assign bus.invOpcode = inv_q;
  assign bus.memErr    = err_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_mips32_mc_control.sv
// Self-checking bench for mips32_mc_control: directed scenarios plus random
// instruction streams with random memory wait states, checked against a trace model.
module tb_mips32_mc_control;

  localparam logic [2:0] A_ADD = 3'b010;
  localparam logic [2:0] A_SUB = 3'b110;
  localparam logic [2:0] A_AND = 3'b000;
  localparam logic [2:0] A_OR  = 3'b001;
  localparam logic [2:0] A_SLT = 3'b111;

  typedef struct packed {
    logic [2:0] st;
    logic       irWrite;
    logic       pcWrite;
    logic       isBeq;
    logic       isBne;
    logic [1:0] pcSrc;
    logic       iOrD;
    logic       memRead;
    logic       memWrite;
    logic       rfWe;
    logic       rfAddrSel;
    logic [1:0] rfDataSel;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [2:0] aluFunc;
    logic       bitXtend;
    logic       invOpcode;
    logic       memErr;
  } obs_t;

  typedef enum {K_R, K_ADDI, K_SLTI, K_ANDI, K_ORI, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_INV} kind_e;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mips32_mc_control_if #(.ALU_FUNC_W(3)) bus_t ();
  mips32_mc_control_if #(.ALU_FUNC_W(3)) bus_n ();

  mips32_mc_control #(.ALU_FUNC_W(3), .MEM_TIMEOUT(15), .TRAP_ON_INVALID(1'b1))
    dut_t (.clk(clk), .rst(rst), .bus(bus_t));
  mips32_mc_control #(.ALU_FUNC_W(3), .MEM_TIMEOUT(15), .TRAP_ON_INVALID(1'b0))
    dut_n (.clk(clk), .rst(rst), .bus(bus_n));

  obs_t obs_t_w, obs_n_w;
  assign obs_t_w = {bus_t.state, bus_t.irWrite, bus_t.pcWrite, bus_t.isBeq, bus_t.isBne,
                    bus_t.pcSrc, bus_t.iOrD, bus_t.memRead, bus_t.memWrite, bus_t.rfWriteEnable,
                    bus_t.rfWriteAddrSel, bus_t.rfWriteDataSel, bus_t.aluSrcA, bus_t.aluSrcB,
                    bus_t.aluFunc, bus_t.bitXtend, bus_t.invOpcode, bus_t.memErr};
  assign obs_n_w = {bus_n.state, bus_n.irWrite, bus_n.pcWrite, bus_n.isBeq, bus_n.isBne,
                    bus_n.pcSrc, bus_n.iOrD, bus_n.memRead, bus_n.memWrite, bus_n.rfWriteEnable,
                    bus_n.rfWriteAddrSel, bus_n.rfWriteDataSel, bus_n.aluSrcA, bus_n.aluSrcB,
                    bus_n.aluFunc, bus_n.bitXtend, bus_n.invOpcode, bus_n.memErr};

  logic [5:0] t_opc  [14] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h0A,
                              6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};
  logic [5:0] t_func [5]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

  // ---------------- reference model: per-instruction expected trace ----------------
  function automatic kind_e kind_of(logic [5:0] o, logic [5:0] f);
    case (o)
      6'h00:   return (f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}) ? K_R : K_INV;
      6'h08:   return K_ADDI;
      6'h0A:   return K_SLTI;
      6'h0C:   return K_ANDI;
      6'h0D:   return K_ORI;
      6'h23:   return K_LW;
      6'h2B:   return K_SW;
      6'h04:   return K_BEQ;
      6'h05:   return K_BNE;
      6'h02:   return K_J;
      default: return K_INV;
    endcase
  endfunction

  function automatic logic [2:0] r_alu(logic [5:0] f);
    case (f)
      6'h20:   return A_ADD;
      6'h22:   return A_SUB;
      6'h24:   return A_AND;
      6'h25:   return A_OR;
      default: return A_SLT;
    endcase
  endfunction

  function automatic obs_t idle(logic [2:0] s);
    obs_t e = '0;
    e.st = s;
    return e;
  endfunction

  function automatic obs_t fetch_exp(logic rdy);
    obs_t e = idle(3'd0);
    e.memRead = 1'b1; e.aluSrcB = 2'b01; e.aluFunc = A_ADD;
    e.irWrite = rdy;  e.pcWrite = rdy;
    return e;
  endfunction

  function automatic obs_t decode_exp();
    obs_t e = idle(3'd1);
    e.aluSrcB = 2'b11; e.aluFunc = A_ADD;
    return e;
  endfunction

  function automatic obs_t exec_exp(kind_e k, logic [5:0] f);
    obs_t e = idle(3'd2);
    case (k)
      K_R:        begin e.aluSrcA = 1'b1; e.aluFunc = r_alu(f); end
      K_ADDI:     begin e.aluSrcB = 2'b10; e.aluFunc = A_ADD; end
      K_SLTI:     begin e.aluSrcB = 2'b10; e.aluFunc = A_SLT; end
      K_ANDI:     begin e.aluSrcB = 2'b10; e.bitXtend = 1'b1; e.aluFunc = A_AND; end
      K_ORI:      begin e.aluSrcB = 2'b10; e.bitXtend = 1'b1; e.aluFunc = A_OR; end
      K_LW, K_SW: begin e.aluSrcA = 1'b1; e.aluSrcB = 2'b10; e.aluFunc = A_ADD; end
      K_BEQ:      begin e.aluSrcA = 1'b1; e.aluFunc = A_SUB; e.pcSrc = 2'b01; e.isBeq = 1'b1; end
      K_BNE:      begin e.aluSrcA = 1'b1; e.aluFunc = A_SUB; e.pcSrc = 2'b01; e.isBne = 1'b1; end
      K_J:        begin e.pcWrite = 1'b1; e.pcSrc = 2'b10; end
      default:    ;
    endcase
    return e;
  endfunction

  function automatic obs_t mem_exp(kind_e k);
    obs_t e = idle(3'd3);
    e.iOrD = 1'b1; e.memRead = (k == K_LW); e.memWrite = (k == K_SW);
    return e;
  endfunction

  function automatic obs_t wb_exp(kind_e k);
    obs_t e = idle(3'd4);
    e.rfWe = 1'b1; e.rfAddrSel = (k == K_R); e.rfDataSel = (k == K_LW) ? 2'b01 : 2'b00;
    return e;
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // ---------------- checking and stimulus helpers ----------------
  task automatic chk(string tag, obs_t got, obs_t exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_op(logic [5:0] o, logic [5:0] f);
    bus_t.opc = o; bus_t.func = f;
    bus_n.opc = o; bus_n.func = f;
  endtask

  task automatic set_rdy(logic r);
    bus_t.memReady = r; bus_n.memReady = r;
  endtask

  task automatic cyc2(logic rdy, obs_t et, obs_t en, bit chk_n, string tag);
    set_rdy(rdy);
    @(negedge clk);
    chk({"t_", tag}, obs_t_w, et);
    if (chk_n) chk({"n_", tag}, obs_n_w, en);
    @(posedge clk); #1;
  endtask

  task automatic cyc(logic rdy, obs_t e, string tag);
    cyc2(rdy, e, e, 1'b1, tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_rdy(1'b0);
    #1;
    chk("t_reset_async", obs_t_w, idle(3'd0));
    @(negedge clk);
    chk("t_reset", obs_t_w, idle(3'd0));
    chk("n_reset", obs_n_w, idle(3'd0));
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic run_instr(logic [5:0] o, logic [5:0] f, int wf, int wm);
    kind_e k = kind_of(o, f);
    set_op(o, f);
    for (int i = 0; i < wf; i++) cyc(1'b0, fetch_exp(1'b0), "fetch_wait");
    cyc(1'b1, fetch_exp(1'b1), "fetch");
    cyc(rnd(), decode_exp(), "decode");
    cyc(rnd(), exec_exp(k, f), "exec");
    if (k == K_LW || k == K_SW) begin
      for (int i = 0; i < wm; i++) cyc(1'b0, mem_exp(k), "mem_wait");
      cyc(1'b1, mem_exp(k), "mem");
    end
    if (k inside {K_R, K_ADDI, K_SLTI, K_ANDI, K_ORI, K_LW})
      cyc(rnd(), wb_exp(k), "wb");
  endtask

  task automatic run_invalid(logic [5:0] o, logic [5:0] f, int n_trap);
    obs_t et, en;
    set_op(o, f);
    cyc(1'b1, fetch_exp(1'b1), "inv_fetch");
    cyc(1'b0, decode_exp(), "inv_decode");
    et = idle(3'd5); et.invOpcode = 1'b1;
    en = fetch_exp(1'b0); en.invOpcode = 1'b1;
    cyc2(1'b0, et, en, 1'b1, "inv_pulse");
    en.invOpcode = 1'b0;
    cyc2(1'b0, et, en, 1'b1, "inv_clear");
    for (int i = 2; i < n_trap; i++) cyc2(rnd(), et, en, 1'b0, "inv_trap");
    do_reset();
  endtask

  // ---------------- directed and random sequence ----------------
  initial begin
    obs_t e;
    int   idx;
    logic [5:0] ro, rf;
    set_op(6'h00, 6'h20);
    set_rdy(1'b0);
    @(posedge clk); #1;
    do_reset();

    // Basic instruction flows
    run_instr(6'h00, 6'h20, 0, 0);
    run_instr(6'h23, 6'h00, 0, 3);
    run_instr(6'h0D, 6'h11, 0, 0);
    run_instr(6'h05, 6'h00, 0, 0);
    run_instr(6'h02, 6'h3F, 1, 0);

    // Random instruction stream with random wait states
    repeat (60) begin
      idx = int'($urandom_range(0, 13));
      ro  = t_opc[idx];
      rf  = (idx < 5) ? t_func[idx] : 6'($urandom);
      run_instr(ro, rf, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    // Ready arriving exactly at the timeout limit wins
    run_instr(6'h00, 6'h2A, 15, 0);
    run_instr(6'h23, 6'h00, 0, 15);

    // Fetch timeout: 15 tolerated low cycles, trap on the next one
    set_op(6'h00, 6'h20);
    for (int i = 0; i < 16; i++) cyc(1'b0, fetch_exp(1'b0), "fetch_to_wait");
    e = idle(3'd5); e.memErr = 1'b1;
    for (int i = 0; i < 4; i++) cyc(rnd(), e, "fetch_to_trap");
    do_reset();
    cyc(1'b1, fetch_exp(1'b1), "post_trap_fetch");
    cyc(1'b0, decode_exp(), "post_trap_decode");
    cyc(1'b0, exec_exp(K_R, 6'h20), "post_trap_exec");
    cyc(1'b0, wb_exp(K_R), "post_trap_wb");

    // Memory-phase timeout on a store
    set_op(6'h2B, 6'h00);
    cyc(1'b1, fetch_exp(1'b1), "sw_fetch");
    cyc(rnd(), decode_exp(), "sw_decode");
    cyc(rnd(), exec_exp(K_SW, 6'h00), "sw_exec");
    for (int i = 0; i < 16; i++) cyc(1'b0, mem_exp(K_SW), "mem_to_wait");
    for (int i = 0; i < 3; i++) cyc(rnd(), e, "mem_to_trap");
    do_reset();

    // Reset asserted while a store is in MEM
    cyc(1'b1, fetch_exp(1'b1), "abort_fetch");
    cyc(rnd(), decode_exp(), "abort_decode");
    cyc(rnd(), exec_exp(K_SW, 6'h00), "abort_exec");
    set_rdy(1'b0);
    @(negedge clk);
    chk("t_abort_mem", obs_t_w, mem_exp(K_SW));
    #2 rst = 1'b1;
    #1 chk("t_abort_now", obs_t_w, idle(3'd0));
    @(negedge clk);
    chk("t_abort_hold", obs_t_w, idle(3'd0));
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(1'b1, fetch_exp(1'b1), "abort_release");
    cyc(rnd(), decode_exp(), "abort_redecode");
    cyc(rnd(), exec_exp(K_SW, 6'h00), "abort_reexec");
    cyc(1'b1, mem_exp(K_SW), "abort_remem");

    // Invalid instructions: trap variant sticks, NOP variant pulses
    run_invalid(6'h3F, 6'h00, 20);
    run_invalid(6'h00, 6'h27, 3);
    run_instr(6'h04, 6'h00, 0, 0);
    run_instr(6'h0C, 6'h00, 2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
